// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue.
// Streams instruction words from a synchronous program ROM into a small
// FIFO and offers the head word to the decode/execute controller over a
// valid/ready handshake. A redirect flushes queued and in-flight words and
// restarts fetching at a new address.
module instr_fetch_queue #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Request stage: next address to fetch.
  logic [ADDR_W-1:0] fetch_pc;

  // Response stage: a word is arriving from the ROM this cycle.
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  // Queue storage and bookkeeping.
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              push;
  logic              pop;

  // Words already queued plus the one still in flight; a new request is
  // only issued if its response is guaranteed a free slot. A pop in the
  // same cycle is deliberately not counted as freeing space.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  assign issue = (state == RUN) && !redirect && (occupancy < DEPTH_OCC);
  assign push  = inflight && !redirect;
  assign pop   = instr_valid && instr_ready && !redirect;

  assign mem_req     = issue;
  assign mem_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_data  = q_data[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];

  // Fetch state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch enable tracking: requests are only issued while running.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request stage -> response stage: advance the fetch address and remember
  // which address the returning word belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue and wins
  // over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Response stage -> queue: capture the returning word with its address.
  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (push) begin
      q_data[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

  // The issue rule must never let a response arrive at a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(DEPTH))));

  // Occupancy can never exceed the queue depth.
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    (count <= CNT_W'(DEPTH)));

endmodule
